// File: rtl/pc_fetch_pkg.sv
// Shared types and default widths for the program-counter / fetch sequencer
// and the branch-target LUT it drives.
package pc_fetch_pkg;

  localparam int PC_W    = 10;
  localparam int PTR_W   = 4;
  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BRANCH  = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  // A Start request is only honoured while the sequencer is parked.
  function automatic logic accepts_start(input state_e s);
    return (s == ST_IDLE) || (s == ST_HALTED);
  endfunction

  // Cycles in which the run counter advances.
  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_BRANCH);
  endfunction

endpackage

// File: rtl/pc_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module pc_fetch_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: advances the PC, parks on halt, and
// resolves taken branches through a registered branch-target LUT pointer.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int            W          = PC_W,
  parameter int            A          = PTR_W,
  parameter logic [W-1:0]  START_ADDR = '0
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Branch,
  input  logic               Taken,
  input  logic               Halt,
  input  logic [A-1:0]       Imm_in,
  input  logic [W-1:0]       Target,
  output logic [A-1:0]       Lut_Addr,
  output logic [W-1:0]       PC,
  output logic               Fetch_Valid,
  output logic               Done,
  output logic [COUNT_W-1:0] Cycle_Count
);

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [A-1:0]   lut_addr_q, lut_addr_d;
  logic           start_accept;
  logic           take_branch;
  logic           run_advance;

  // Control decode shared by the next-state and datapath logic.
  always_comb begin
    start_accept = accepts_start(state_q) && Start;
    run_advance  = (state_q == ST_RUN) && !Stall && !Halt;
    take_branch  = run_advance && Branch && Taken;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!Stall) begin
          if (Halt)                 state_d = ST_HALTED;
          else if (Branch && Taken) state_d = ST_BRANCH;
        end
      end
      ST_BRANCH: state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from the state register alone, never from inputs.
  always_comb begin
    Fetch_Valid = (state_q == ST_RUN);
    Done        = (state_q == ST_HALTED);
  end

  // PC: restart, branch-target load, or sequential increment (wraps at 2^W).
  always_comb begin
    pc_d = pc_q;
    if (start_accept) begin
      pc_d = START_ADDR;
    end else if (state_q == ST_BRANCH) begin
      pc_d = Target;
    end else if (run_advance && !take_branch) begin
      pc_d = pc_q + W'(1);
    end
  end

  // The pointer only moves when a taken branch is accepted; it is the LUT
  // address during the following bubble cycle.
  always_comb begin
    lut_addr_d = lut_addr_q;
    if (take_branch) begin
      lut_addr_d = Imm_in;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc_q       <= START_ADDR;
      lut_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      lut_addr_q <= lut_addr_d;
    end
  end

  pc_fetch_sat_counter #(
    .WIDTH (COUNT_W)
  ) u_cycle_count (
    .clk   (clk),
    .rst_n (Reset),
    .clr   (start_accept),
    .en    (is_active(state_q)),
    .count (Cycle_Count)
  );

  assign PC       = pc_q;
  assign Lut_Addr = lut_addr_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, hand-written
// reset/saturation sequences, and random stimulus against a behavioural model.
module tb_pc_fetch;

  localparam int W = 10;
  localparam int A = 4;

  logic          clk;
  logic          rst_n;
  logic          start, stall, branch, taken, halt;
  logic [A-1:0]  imm_in;
  logic [W-1:0]  target;
  logic [A-1:0]  lut_addr;
  logic [W-1:0]  pc;
  logic          fetch_valid, done;
  logic [15:0]   cycle_count;

  logic [W-1:0]  lut_mem [16];

  int total = 0;
  int bad   = 0;

  // The bench plays the role of the combinational branch-target LUT.
  assign target = lut_mem[lut_addr];

  pc_fetch dut (
    .clk         (clk),
    .Reset       (rst_n),
    .Start       (start),
    .Stall       (stall),
    .Branch      (branch),
    .Taken       (taken),
    .Halt        (halt),
    .Imm_in      (imm_in),
    .Target      (target),
    .Lut_Addr    (lut_addr),
    .PC          (pc),
    .Fetch_Valid (fetch_valid),
    .Done        (done),
    .Cycle_Count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic b, input logic t,
                       input logic h, input logic [A-1:0] imm);
    start  = s;
    stall  = st;
    branch = b;
    taken  = t;
    halt   = h;
    imm_in = imm;
  endtask

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic         start, stall, branch, taken, halt;
    logic [A-1:0] imm;
    logic [W-1:0] pc;
    logic         fv, done;
    logic [A-1:0] ptr;
    logic [15:0]  cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic st, input logic b, input logic t,
                     input logic h, input logic [A-1:0] imm, input logic [W-1:0] e_pc,
                     input logic e_fv, input logic e_done, input logic [A-1:0] e_ptr,
                     input logic [15:0] e_cnt);
    vec_t v;
    v.start = s; v.stall = st; v.branch = b; v.taken = t; v.halt = h; v.imm = imm;
    v.pc = e_pc; v.fv = e_fv; v.done = e_done; v.ptr = e_ptr; v.cnt = e_cnt;
    vq.push_back(v);
  endtask

  // Behavioural reference: a program either is not running, is running
  // (possibly waiting one bubble for a branch target), or has halted.
  logic         m_running, m_bubble, m_halted;
  logic [W-1:0] m_pc;
  logic [A-1:0] m_ptr;
  int           m_cnt;

  task automatic model_reset();
    m_running = 1'b0; m_bubble = 1'b0; m_halted = 1'b0;
    m_pc = '0; m_ptr = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (m_running) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_bubble) begin
        m_pc     = lut_mem[m_ptr];
        m_bubble = 1'b0;
      end else if (!stall) begin
        if (halt) begin
          m_running = 1'b0;
          m_halted  = 1'b1;
        end else if (branch && taken) begin
          m_ptr    = imm_in;
          m_bubble = 1'b1;
        end else begin
          m_pc = W'((int'(m_pc) + 1) % 1024);
        end
      end
    end else if (start) begin
      m_running = 1'b1;
      m_halted  = 1'b0;
      m_pc      = '0;
      m_cnt     = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_pc"},   int'(pc),          int'(m_pc));
    check({tag, "_fv"},   int'(fetch_valid), int'(m_running && !m_bubble));
    check({tag, "_done"}, int'(done),        int'(m_halted));
    check({tag, "_ptr"},  int'(lut_addr),    int'(m_ptr));
    check({tag, "_cnt"},  int'(cycle_count), m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = W'(i * 37 + 5);
    lut_mem[3] = 10'h2A5;
    lut_mem[7] = 10'h3FE;

    // Directed vectors: inputs applied for one cycle, outputs checked after the edge.
    add(1,0,0,0,0,0, 10'h000,1,0,0,0);
    for (int i = 1; i <= 7; i++) add(0,0,0,0,0,0, W'(i),1,0,0,16'(i));
    add(0,0,1,1,0,3, 10'h007,0,0,3,8);
    add(0,0,0,0,0,0, 10'h2A5,1,0,3,9);
    add(0,0,1,0,0,9, 10'h2A6,1,0,3,10);
    add(0,0,1,1,1,5, 10'h2A6,0,1,3,11);
    add(0,0,0,0,0,0, 10'h2A6,0,1,3,11);
    add(1,0,0,0,0,0, 10'h000,1,0,3,0);
    for (int i = 1; i <= 4; i++) add(0,0,0,0,0,0, W'(i),1,0,3,16'(i));
    add(0,1,1,1,1,6, 10'h004,1,0,3,5);
    add(0,1,0,0,1,0, 10'h004,1,0,3,6);
    add(0,1,0,0,1,0, 10'h004,1,0,3,7);
    add(0,0,0,0,1,0, 10'h004,0,1,3,8);
    add(1,0,0,0,0,0, 10'h000,1,0,3,0);
    add(0,0,1,1,0,7, 10'h000,0,0,7,1);
    add(0,0,0,0,0,0, 10'h3FE,1,0,7,2);
    add(0,0,0,0,0,0, 10'h3FF,1,0,7,3);
    add(0,0,0,0,0,0, 10'h000,1,0,7,4);
    add(0,0,1,0,0,2, 10'h001,1,0,7,5);
    add(1,0,0,0,0,0, 10'h002,1,0,7,6);
    add(0,0,1,1,0,3, 10'h002,0,0,3,7);
    add(1,1,1,1,1,9, 10'h2A5,1,0,3,8);

    rst_n = 1'b0;
    drive(0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    check("rst_pc",   int'(pc),          0);
    check("rst_ptr",  int'(lut_addr),    0);
    check("rst_fv",   int'(fetch_valid), 0);
    check("rst_done", int'(done),        0);
    check("rst_cnt",  int'(cycle_count), 0);
    rst_n = 1'b1;
    drive(0,0,1,1,1,4);
    step_clk();
    check("idle_fv",  int'(fetch_valid), 0);
    check("idle_pc",  int'(pc),          0);
    check("idle_cnt", int'(cycle_count), 0);

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stall, vq[i].branch, vq[i].taken, vq[i].halt, vq[i].imm);
      step_clk();
      check($sformatf("v%0d_pc", i),   int'(pc),          int'(vq[i].pc));
      check($sformatf("v%0d_fv", i),   int'(fetch_valid), int'(vq[i].fv));
      check($sformatf("v%0d_done", i), int'(done),        int'(vq[i].done));
      check($sformatf("v%0d_ptr", i),  int'(lut_addr),    int'(vq[i].ptr));
      check($sformatf("v%0d_cnt", i),  int'(cycle_count), int'(vq[i].cnt));
    end

    // Reset asserted while the branch bubble is in flight.
    drive(0,0,1,1,0,7);
    @(posedge clk);
    #2;
    check("midbr_fv_before", int'(fetch_valid), 0);
    rst_n = 1'b0;
    #1;
    check("midbr_pc",   int'(pc),          0);
    check("midbr_ptr",  int'(lut_addr),    0);
    check("midbr_fv",   int'(fetch_valid), 0);
    check("midbr_done", int'(done),        0);
    check("midbr_cnt",  int'(cycle_count), 0);
    drive(0,0,0,0,0,0);
    @(negedge clk);
    rst_n = 1'b1;
    step_clk();
    check("postrst_pc", int'(pc),          0);
    check("postrst_fv", int'(fetch_valid), 0);

    // Random stimulus against the model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, A'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) lut_mem[$urandom_range(0, 15)] = W'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model($sformatf("r%0d", n));
    end

    // Counter saturation: a long stalled run.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,0,0,0,0);
    step_clk();
    drive(0,1,0,0,0,0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", int'(cycle_count), 16'hFFFE);
    repeat (3) step_clk();
    check("sat_ffff", int'(cycle_count), 16'hFFFF);
    check("sat_pc",   int'(pc),          0);
    check("sat_fv",   int'(fetch_valid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
